hazard_ctrl: RTL and testbench

//  Stall/flush controller on the producer side of the ID_EX register. Consumes ID_EX outputs
//  (MemRead_o, RDaddr_o) and the ID-stage operand addresses, and generates the enables,

---
 rtl/riscv_pipe_pkg.sv | 11 +
 rtl/hazard_cmp.sv | 14 +
 rtl/hazard_ctrl.sv | 97 +++++++++
 tb/tb_hazard_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline encodings for hazard control and forwarding
package riscv_pipe_pkg;
    typedef enum logic [1:0] {
        HZ_IDLE  = 2'd0,
        HZ_LU    = 2'd1,
        HZ_FLUSH = 2'd2,
        HZ_MEMW  = 2'd3
    } hz_state_t;
    localparam logic [4:0]  REG_X0    = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: load-use match of ID operands against the load destination in ID_EX
module hazard_cmp
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic       mem_read,
    input  logic [4:0] rd,
    output logic       hit
);
    assign hit = mem_read && rd != REG_X0 && ((use_rs && rs == rd) || (use_rt && rt == rd));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-wait freeze for the ID/EX boundary
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_DEPTH    = 2,
    parameter int MEM_TIMEOUT    = 255,
    parameter int PERF_W         = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic              uses_rs_i,
    input  logic              uses_rt_i,
    input  logic              ex_MemRead_i,
    input  logic [4:0]        ex_RDaddr_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              PCwrite_o,
    output logic              IF_IDwrite_o,
    output logic              ctrl_bubble_o,
    output logic              IF_IDflush_o,
    output logic              pipe_hold_o,
    output logic              mem_timeout_o,
    output logic [PERF_W-1:0] stall_cycles_o
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);
    hz_state_t state, state_n, saved, es;
    logic [1:0] cnt, cnt_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic lu, mw;
    hazard_cmp u_cmp (
        .rs(RSaddr_i), .rt(RTaddr_i), .use_rs(uses_rs_i), .use_rt(uses_rt_i),
        .mem_read(ex_MemRead_i), .rd(ex_RDaddr_i), .hit(lu)
    );
    assign mw = mem_req_i && !mem_ready_i;
    assign wait_n = mw ? (wait_cnt == WMAX ? wait_cnt : wait_cnt + 1'b1) : '0;
    // The release cycle of a memory wait already executes the saved state; cnt is frozen meanwhile.
    always_comb begin
        es = state == HZ_MEMW ? saved : state;
        state_n = es;
        cnt_n = cnt;
        PCwrite_o = 1'b1;
        IF_IDwrite_o = 1'b1;
        ctrl_bubble_o = 1'b0;
        IF_IDflush_o = 1'b0;
        pipe_hold_o = 1'b0;
        if (mw) begin
            pipe_hold_o = 1'b1;
            PCwrite_o = 1'b0;
            IF_IDwrite_o = 1'b0;
            state_n = HZ_MEMW;
        end else if (branch_taken_i) begin
            IF_IDflush_o = 1'b1;
            ctrl_bubble_o = 1'b1;
            state_n = FLUSH_DEPTH > 1 ? HZ_FLUSH : HZ_IDLE;
            cnt_n = 2'(FLUSH_DEPTH - 1);
        end else if (es == HZ_FLUSH) begin
            ctrl_bubble_o = 1'b1;
            cnt_n = cnt - 2'd1;
            state_n = cnt == 2'd1 ? HZ_IDLE : HZ_FLUSH;
        end else if (es == HZ_LU || lu) begin
            PCwrite_o = 1'b0;
            IF_IDwrite_o = 1'b0;
            ctrl_bubble_o = 1'b1;
            cnt_n = es == HZ_LU ? cnt - 2'd1 : 2'(LOAD_USE_STALL - 1);
            state_n = (es == HZ_LU ? cnt == 2'd1 : LOAD_USE_STALL == 1) ? HZ_IDLE : HZ_LU;
        end
        if (RESET) begin
            PCwrite_o = 1'b0;
            IF_IDwrite_o = 1'b0;
            ctrl_bubble_o = 1'b1;
            IF_IDflush_o = 1'b1;
            pipe_hold_o = 1'b0;
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= HZ_IDLE;
            saved <= HZ_IDLE;
            cnt <= '0;
            wait_cnt <= '0;
            mem_timeout_o <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            wait_cnt <= wait_n;
            if (mw && state != HZ_MEMW) saved <= state;
            mem_timeout_o <= mem_timeout_o | (wait_n == WMAX);
            if (!PCwrite_o && !(&stall_cycles_o)) stall_cycles_o <= stall_cycles_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (LOAD_USE_STALL=3, FLUSH_DEPTH=2, MEM_TIMEOUT=3)
module tb_hazard_ctrl;
    localparam logic [4:0] RUN = 5'b11000, STALL = 5'b00100, BR = 5'b11110;
    localparam logic [4:0] FL = 5'b11100, HOLD = 5'b00001, RST = 5'b00110;
    logic CLK = 1'b0, RESET = 1'b1;
    logic [4:0] RSaddr_i, RTaddr_i, ex_RDaddr_i;
    logic uses_rs_i, uses_rt_i, ex_MemRead_i, branch_taken_i, mem_req_i, mem_ready_i;
    logic PCwrite_o, IF_IDwrite_o, ctrl_bubble_o, IF_IDflush_o, pipe_hold_o, mem_timeout_o;
    logic [15:0] stall_cycles_o;
    int n_chk = 0, n_fail = 0;
    logic [4:0] sb[$];
    hazard_ctrl #(.LOAD_USE_STALL(3), .FLUSH_DEPTH(2), .MEM_TIMEOUT(3), .PERF_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .uses_rs_i(uses_rs_i), .uses_rt_i(uses_rt_i), .ex_MemRead_i(ex_MemRead_i),
        .ex_RDaddr_i(ex_RDaddr_i), .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i),
        .mem_ready_i(mem_ready_i), .PCwrite_o(PCwrite_o), .IF_IDwrite_o(IF_IDwrite_o),
        .ctrl_bubble_o(ctrl_bubble_o), .IF_IDflush_o(IF_IDflush_o), .pipe_hold_o(pipe_hold_o),
        .mem_timeout_o(mem_timeout_o), .stall_cycles_o(stall_cycles_o)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic quiet();
        RSaddr_i = 5'd0; RTaddr_i = 5'd0; ex_RDaddr_i = 5'd0;
        uses_rs_i = 1'b0; uses_rt_i = 1'b0; ex_MemRead_i = 1'b0;
        branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
    endtask
    task automatic set_lu();
        ex_MemRead_i = 1'b1; ex_RDaddr_i = 5'd5; RSaddr_i = 5'd5; uses_rs_i = 1'b1;
    endtask
    // outputs are packed as {PCwrite, IF_IDwrite, bubble, flush, hold}
    task automatic tick(input string tag, input logic [4:0] e);
        logic [4:0] exp;
        sb.push_back(e);
        #1;
        exp = sb.pop_front();
        check(tag, {27'd0, PCwrite_o, IF_IDwrite_o, ctrl_bubble_o, IF_IDflush_o, pipe_hold_o},
              {27'd0, exp});
        @(negedge CLK);
    endtask
    initial begin
        quiet();
        #1;
        tick("reset", RST);
        check("reset_stall", 32'(stall_cycles_o), 32'd0);
        check("reset_tmo", 32'(mem_timeout_o), 32'd0);
        RESET = 1'b0;
        tick("idle", RUN);
        set_lu(); tick("lu0", STALL);
        quiet(); tick("lu1", STALL); tick("lu2", STALL); tick("lu_done", RUN);
        check("lu_stall_cnt", 32'(stall_cycles_o), 32'd3);
        ex_MemRead_i = 1'b1; uses_rs_i = 1'b1; tick("x0", RUN);
        quiet(); ex_MemRead_i = 1'b1; ex_RDaddr_i = 5'd7; RTaddr_i = 5'd7; RSaddr_i = 5'd3;
        uses_rs_i = 1'b1; tick("rt_unused", RUN);
        uses_rt_i = 1'b1; tick("rt_hit", STALL);
        quiet(); tick("rt1", STALL); tick("rt2", STALL); tick("rt_done", RUN);
        check("rt_stall_cnt", 32'(stall_cycles_o), 32'd6);
        branch_taken_i = 1'b1; tick("br", BR);
        quiet(); tick("br_flush", FL); tick("br_done", RUN);
        set_lu(); branch_taken_i = 1'b1; tick("br_lu", BR);
        quiet(); tick("br_lu_flush", FL); tick("br_lu_done", RUN);
        check("br_stall_cnt", 32'(stall_cycles_o), 32'd6);
        set_lu(); tick("abort_lu", STALL);
        quiet(); branch_taken_i = 1'b1; tick("abort_br", BR);
        quiet(); tick("abort_flush", FL); tick("abort_done", RUN);
        set_lu(); tick("mw_lu", STALL);
        quiet(); mem_req_i = 1'b1; tick("mw0", HOLD); tick("mw1", HOLD);
        check("tmo_early", 32'(mem_timeout_o), 32'd0);
        tick("mw2", HOLD);
        check("tmo_set", 32'(mem_timeout_o), 32'd1);
        tick("mw3", HOLD);
        mem_ready_i = 1'b1; tick("mw_release", STALL);
        quiet(); tick("mw_rest", STALL); tick("mw_done", RUN);
        check("tmo_sticky", 32'(mem_timeout_o), 32'd1);
        check("mw_stall_cnt", 32'(stall_cycles_o), 32'd14);
        set_lu(); tick("rl_lu", STALL);
        quiet(); tick("rl_lu1", STALL);
        #2 RESET = 1'b1;
        tick("async_rst", RST);
        check("async_stall", 32'(stall_cycles_o), 32'd0);
        check("async_tmo", 32'(mem_timeout_o), 32'd0);
        RESET = 1'b0;
        tick("post_rst", RUN);
        check("post_stall", 32'(stall_cycles_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
